// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Brings an asynchronous ripple-counter value and its counted-max flag into
//   the clk domain. A 2-flop synchronizer feeds a run-length stability
//   filter. Accepted values drive wrap detection, a saturating wrap total and
//   a per-wrap snapshot that is offered over a valid/ready handshake.
//   Optional feature macro: RC_SAMPLER_RANGE_CHECK_EN (adds sticky range_err).
module ripple_count_sampler #(
  parameter int RC_WIDTH      = 3,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [RC_WIDTH-1:0]   rc_count,
  input  logic                  rc_counted_max,
  input  logic [RC_WIDTH-1:0]   max_count,
  input  logic                  sample_en,
  input  logic                  snap_ready,
  output logic [RC_WIDTH-1:0]   stable_count,
  output logic                  stable_max,
  output logic                  count_valid,
  output logic                  wrap_pulse,
  output logic [WRAP_WIDTH-1:0] wrap_total,
  output logic                  wrap_ovf,
  output logic                  snap_valid,
  output logic [WRAP_WIDTH-1:0] snap_wraps,
  output logic                  snap_missed
`ifdef RC_SAMPLER_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int         SYNC_W  = RC_WIDTH + 1;
  localparam logic [3:0] RUN_MAX = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    TRACK  = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_W-1:0]       sync_q1, sync_q2, prev_q;
  logic [1:0]              fill_q;
  logic [3:0]              run_q, run_d;
  logic                    sample_real, prev_real, match, differs;
  logic                    accept, wrap_det, capture, missed;
  logic [RC_WIDTH-1:0]     sync_count;
  logic                    wrap_sat;
  logic [WRAP_WIDTH-1:0]   wrap_next;

  assign sync_count = sync_q2[RC_WIDTH-1:0];

  // Two-stage synchronizer on {counted_max, count}; skew is left to the filter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {rc_counted_max, rc_count};
      sync_q2 <= sync_q1;
    end
  end

  // Filter history: previous sample, pipeline fill level and run length
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_q <= '0;
      fill_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= sync_q2;
      if (fill_q != 2'd3)
        fill_q <= fill_q + 2'd1;
      run_q  <= run_d;
    end
  end

  // Run-length update and acceptance; reset contents of the pipeline never count as samples
  always_comb begin
    sample_real = (fill_q >= 2'd2);
    prev_real   = (fill_q == 2'd3);
    match       = prev_real && (sync_q2 == prev_q);
    run_d       = 4'd0;
    if (match)
      run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
    differs     = (sync_q2 != {stable_max, stable_count});
    accept      = sample_real && (run_d == RUN_MAX) &&
                  ((state_q == SETTLE) || differs);
    wrap_det    = accept && (state_q != SETTLE) && sample_en &&
                  (sync_count < stable_count);
  end

  // Filtered value register, loaded on each acceptance
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stable_count <= '0;
      stable_max   <= 1'b0;
    end else if (accept) begin
      stable_count <= sync_count;
      stable_max   <= sync_q2[RC_WIDTH];
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      state_q <= SETTLE;
    else
      state_q <= state_d;
  end

  // FSM next state: a wrap seen while a snapshot is pending is reported as missed, never captured
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    missed  = 1'b0;
    unique case (state_q)
      SETTLE: begin
        if (accept)
          state_d = TRACK;
      end
      TRACK: begin
        if (wrap_det) begin
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (snap_ready)
          state_d = TRACK;
        if (wrap_det)
          missed = 1'b1;
      end
      default: state_d = SETTLE;
    endcase
  end

  // Saturating increment of the wrap total
  always_comb begin
    wrap_sat  = &wrap_total;
    wrap_next = wrap_sat ? wrap_total : wrap_total + 1'b1;
  end

  // Wrap accounting, snapshot capture and one-cycle event pulses
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wrap_pulse  <= 1'b0;
      snap_missed <= 1'b0;
      wrap_total  <= '0;
      wrap_ovf    <= 1'b0;
      snap_wraps  <= '0;
    end else begin
      wrap_pulse  <= wrap_det;
      snap_missed <= missed;
      if (wrap_det) begin
        wrap_total <= wrap_next;
        if (wrap_sat)
          wrap_ovf <= 1'b1;
      end
      if (capture)
        snap_wraps <= wrap_next;
    end
  end

  assign count_valid = (state_q != SETTLE);
  assign snap_valid  = (state_q == HOLD);

`ifdef RC_SAMPLER_RANGE_CHECK_EN
  // Sticky flag for an accepted count at or beyond the programmed modulus
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      range_err <= 1'b0;
    else if (accept && (max_count != '0) && (sync_count >= max_count))
      range_err <= 1'b1;
  end
`else
  // max_count only feeds the range checker; keep the port referenced without adding logic that matters
  logic unused_max_count;
  assign unused_max_count = ^max_count;
`endif

endmodule

// File: tb/tb_ripple_count_sampler.sv
// tb_ripple_count_sampler
//   Directed bench for ripple_count_sampler with WRAP_WIDTH=2 so saturation is
//   reachable. Stimulus pushes expected wrap totals / snapshots / missed
//   reports into queues; a monitor pops them whenever the DUT shows the event.
//   Honors RC_SAMPLER_RANGE_CHECK_EN when defined.
module tb_ripple_count_sampler;

  localparam int RC_W   = 3;
  localparam int STABLE = 2;
  localparam int WRAP_W = 2;

  logic              clk;
  logic              clr;
  logic [RC_W-1:0]   rc_count;
  logic              rc_counted_max;
  logic [RC_W-1:0]   max_count;
  logic              sample_en;
  logic              snap_ready;
  logic [RC_W-1:0]   stable_count;
  logic              stable_max;
  logic              count_valid;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_total;
  logic              wrap_ovf;
  logic              snap_valid;
  logic [WRAP_W-1:0] snap_wraps;
  logic              snap_missed;
`ifdef RC_SAMPLER_RANGE_CHECK_EN
  logic              range_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [WRAP_W-1:0] exp_wrap_q[$];
  logic [WRAP_W-1:0] exp_snap_q[$];
  logic [WRAP_W-1:0] exp_missed_q[$];

  ripple_count_sampler #(
    .RC_WIDTH     (RC_W),
    .STABLE_CYCLES(STABLE),
    .WRAP_WIDTH   (WRAP_W)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .rc_count      (rc_count),
    .rc_counted_max(rc_counted_max),
    .max_count     (max_count),
    .sample_en     (sample_en),
    .snap_ready    (snap_ready),
    .stable_count  (stable_count),
    .stable_max    (stable_max),
    .count_valid   (count_valid),
    .wrap_pulse    (wrap_pulse),
    .wrap_total    (wrap_total),
    .wrap_ovf      (wrap_ovf),
    .snap_valid    (snap_valid),
    .snap_wraps    (snap_wraps),
    .snap_missed   (snap_missed)
`ifdef RC_SAMPLER_RANGE_CHECK_EN
    ,
    .range_err     (range_err)
`endif
  );

  // Free-running system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive a counter value, then wait n clocks; always entered and left 1ns after a rising edge
  task automatic applyStimulus(input logic [RC_W-1:0] value, input logic flag, input int n);
    rc_count       = value;
    rc_counted_max = flag;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [RC_W-1:0] value);
    clr            = 1'b1;
    rc_count       = value;
    rc_counted_max = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: compare every DUT event against the next queued expectation
  always @(negedge clk) begin
    if (!clr) begin
      if (wrap_pulse) begin
        if (exp_wrap_q.size() == 0)
          checkOutput("unexpected_wrap_pulse", 32'd1, 32'd0);
        else
          checkOutput("wrap_total_at_pulse", 32'(wrap_total), 32'(exp_wrap_q.pop_front()));
      end
      if (snap_valid && snap_ready) begin
        if (exp_snap_q.size() == 0)
          checkOutput("unexpected_snapshot", 32'd1, 32'd0);
        else
          checkOutput("snap_wraps_at_handshake", 32'(snap_wraps), 32'(exp_snap_q.pop_front()));
      end
      if (snap_missed) begin
        if (exp_missed_q.size() == 0)
          checkOutput("unexpected_snap_missed", 32'd1, 32'd0);
        else
          checkOutput("wrap_total_at_missed", 32'(wrap_total), 32'(exp_missed_q.pop_front()));
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    clr            = 1'b1;
    rc_count       = '0;
    rc_counted_max = 1'b0;
    max_count      = 3'd7;
    sample_en      = 1'b1;
    snap_ready     = 1'b1;

    // Reset state and acceptance latency with rc_count=3 held
    doReset(3'd3);
    checkOutput("reset_count_valid",  32'(count_valid),  32'd0);
    checkOutput("reset_stable_count", 32'(stable_count), 32'd0);
    checkOutput("reset_wrap_total",   32'(wrap_total),   32'd0);
    checkOutput("reset_snap_valid",   32'(snap_valid),   32'd0);
    checkOutput("reset_wrap_ovf",     32'(wrap_ovf),     32'd0);
    checkOutput("reset_snap_wraps",   32'(snap_wraps),   32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("count_valid_at_clk3",  32'(count_valid),  32'd0);
    @(posedge clk);
    #1;
    checkOutput("count_valid_at_clk4",  32'(count_valid),  32'd1);
    checkOutput("stable_count_at_clk4", 32'(stable_count), 32'd3);
    applyStimulus(3'd3, 1'b0, 6);
    checkOutput("no_wrap_after_settle", 32'(wrap_total), 32'd0);

    // Count 0..6 then back to 0: exactly one wrap, snapshot taken immediately
    doReset(3'd0);
    applyStimulus(3'd0, 1'b0, 8);
    for (int v = 1; v <= 6; v++)
      applyStimulus(3'(v), (v == 6), 8);
    checkOutput("stable_count_at_6", 32'(stable_count), 32'd6);
    checkOutput("stable_max_at_6",   32'(stable_max),   32'd1);
    exp_wrap_q.push_back(2'd1);
    exp_snap_q.push_back(2'd1);
    applyStimulus(3'd0, 1'b0, 8);
    checkOutput("stable_count_after_wrap", 32'(stable_count), 32'd0);
    checkOutput("stable_max_after_wrap",   32'(stable_max),   32'd0);
    checkOutput("snap_valid_after_ack",    32'(snap_valid),   32'd0);
    checkOutput("wrap_total_one",          32'(wrap_total),   32'd1);

    // One-cycle glitch 6->2->6 is filtered out
    applyStimulus(3'd6, 1'b0, 8);
    applyStimulus(3'd2, 1'b0, 1);
    applyStimulus(3'd6, 1'b0, 8);
    checkOutput("glitch_stable_count", 32'(stable_count), 32'd6);
    checkOutput("glitch_wrap_total",   32'(wrap_total),   32'd1);

    // Three wraps with no consumer: first is captured, next two are missed
    doReset(3'd0);
    snap_ready = 1'b0;
    applyStimulus(3'd0, 1'b0, 8);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(3'd5, 1'b0, 8);
      exp_wrap_q.push_back(2'(i));
      if (i == 1)
        exp_snap_q.push_back(2'd1);
      else
        exp_missed_q.push_back(2'(i));
      applyStimulus(3'd1, 1'b0, 8);
    end
    checkOutput("hold_snap_valid", 32'(snap_valid), 32'd1);
    checkOutput("hold_snap_wraps", 32'(snap_wraps), 32'd1);
    checkOutput("hold_wrap_total", 32'(wrap_total), 32'd3);
    checkOutput("hold_wrap_ovf",   32'(wrap_ovf),   32'd0);

    // Fourth wrap lands on the handshake cycle and at saturation
    applyStimulus(3'd5, 1'b0, 8);
    exp_wrap_q.push_back(2'd3);
    exp_missed_q.push_back(2'd3);
    applyStimulus(3'd1, 1'b0, 3);
    snap_ready = 1'b1;
    applyStimulus(3'd1, 1'b0, 5);
    checkOutput("sat_wrap_ovf",       32'(wrap_ovf),   32'd1);
    checkOutput("sat_wrap_total",     32'(wrap_total), 32'd3);
    checkOutput("ack_back_to_track",  32'(snap_valid), 32'd0);

    // Fifth wrap is captured again from TRACK; then reset lands mid-HOLD
    snap_ready = 1'b0;
    applyStimulus(3'd5, 1'b0, 8);
    exp_wrap_q.push_back(2'd3);
    applyStimulus(3'd1, 1'b0, 8);
    checkOutput("fifth_snap_valid", 32'(snap_valid), 32'd1);
    checkOutput("fifth_snap_wraps", 32'(snap_wraps), 32'd3);
    checkOutput("fifth_wrap_ovf",   32'(wrap_ovf),   32'd1);
    clr = 1'b1;
    #1;
    checkOutput("clr_snap_valid",   32'(snap_valid),   32'd0);
    checkOutput("clr_snap_wraps",   32'(snap_wraps),   32'd0);
    checkOutput("clr_wrap_total",   32'(wrap_total),   32'd0);
    checkOutput("clr_wrap_ovf",     32'(wrap_ovf),     32'd0);
    checkOutput("clr_count_valid",  32'(count_valid),  32'd0);
    checkOutput("clr_stable_count", 32'(stable_count), 32'd0);
    snap_ready = 1'b1;

    // sample_en=0 still updates the count but detects no wrap; range flag is sticky
    max_count = 3'd5;
    sample_en = 1'b1;
    doReset(3'd0);
    applyStimulus(3'd0, 1'b0, 8);
`ifdef RC_SAMPLER_RANGE_CHECK_EN
    checkOutput("range_err_clear", 32'(range_err), 32'd0);
`endif
    applyStimulus(3'd6, 1'b0, 8);
    checkOutput("range_stable_6", 32'(stable_count), 32'd6);
`ifdef RC_SAMPLER_RANGE_CHECK_EN
    checkOutput("range_err_set", 32'(range_err), 32'd1);
`endif
    sample_en = 1'b0;
    applyStimulus(3'd2, 1'b0, 8);
    checkOutput("noen_stable_2",   32'(stable_count), 32'd2);
    checkOutput("noen_wrap_total", 32'(wrap_total),   32'd0);
`ifdef RC_SAMPLER_RANGE_CHECK_EN
    checkOutput("range_err_sticky", 32'(range_err), 32'd1);
`endif

    // Every queued expectation must have been consumed by the monitor
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_wrap_events",   32'(exp_wrap_q.size()),   32'd0);
    checkOutput("pending_snap_events",   32'(exp_snap_q.size()),   32'd0);
    checkOutput("pending_missed_events", 32'(exp_missed_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Downstream consumer of the ripple counter.
- Brings the asynchronous ripple count and its counted-max flag into the system clock domain through a 2-flop synchronizer and a stability filter.
- Detects counter wrap-around, accumulates a wrap total, and offers per-wrap snapshots over a valid/ready handshake to the next stage.

Parameters:
- RC_WIDTH, 3, width of the ripple count being sampled.
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a value is accepted (legal range 1..15).
- WRAP_WIDTH, 8, width of the wrap accumulator.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- rc_count  input  RC_WIDTH  asynchronous ripple counter value.
- rc_counted_max  input  1  asynchronous counted-max flag from the ripple counter.
- max_count  input  RC_WIDTH  quasi-static modulus, same value programmed into the counter.
- sample_en  input  1  enables wrap detection and accumulation.
- snap_ready  input  1  downstream accepts the snapshot.
- stable_count  output  RC_WIDTH  last filtered count.
- stable_max  output  1  filtered counted-max flag.
- count_valid  output  1  high once stable_count holds a filtered value.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- wrap_total  output  WRAP_WIDTH  saturating wrap count.
- wrap_ovf  output  1  sticky flag: a wrap occurred while wrap_total was saturated.
- snap_valid  output  1  snapshot available.
- snap_wraps  output  WRAP_WIDTH  wrap_total captured at the wrap.
- snap_missed  output  1  one-cycle pulse when a wrap occurs while a snapshot is pending.

Behaviour:
- Reset (clr=1, asynchronous):
  - All synchronizer flops, filter state, stable_count, stable_max, wrap_total and snap_wraps = 0.
  - count_valid, wrap_pulse, wrap_ovf, snap_valid and snap_missed = 0.
  - FSM = SETTLE.
  - Reset mid-handshake drops any pending snapshot without a pulse.
- Synchronizer:
  - Two flops per bit on {rc_counted_max, rc_count}; sync value = second stage.
  - No gray coding; bits may be skewed during a ripple, which the filter rejects.
- Filter:
  - Compares the sync value with its previous-cycle value and runs a run-length counter.
  - Counter clears on mismatch; counts up on match, saturating at STABLE_CYCLES-1.
  - When the run length reaches STABLE_CYCLES-1 and the sync value differs from stable_{count,max}, load it into stable_{count,max} and raise an internal update strobe for one cycle.
  - STABLE_CYCLES=1 means load every cycle the value changes.
  - Minimum latency from an rc_count change to stable_count = 2 + STABLE_CYCLES clocks.
- FSM:
  - SETTLE: waits for the first filter acceptance, including one whose value equals the reset value of 0. That acceptance loads stable_count, sets count_valid=1 and moves to TRACK. No wrap is detected on this first load.
  - TRACK: a wrap is an update with new stable_count < old stable_count while sample_en=1. On a wrap:
    - wrap_pulse=1 for one cycle.
    - wrap_total increments, saturating at all-ones; a wrap at saturation sets wrap_ovf, cleared only by clr.
    - snap_wraps = the post-increment wrap_total, snap_valid=1, move to HOLD.
  - HOLD: snap_valid and snap_wraps stay stable until snap_valid&&snap_ready, then return to TRACK the next cycle.
    - A further wrap in HOLD still pulses wrap_pulse and updates wrap_total, but does not overwrite snap_wraps; it pulses snap_missed instead.
    - If a wrap and the handshake occur in the same cycle, the handshake completes and the new wrap is reported as snap_missed; no back-to-back capture.
- sample_en=0: filtering and stable_count updates continue, wrap detection is suppressed, and a pending snapshot can still complete.
- count_valid, once set, stays 1 until clr.

Optional Feature:
- Macro RC_SAMPLER_RANGE_CHECK_EN.
- Defined: adds output range_err (1 bit), a sticky flag set when an accepted stable_count >= max_count while max_count != 0. It is cleared only by clr and its reset value is 0.
- Not defined: port range_err absent, no comparator logic.

Test Plan:
- Reset then hold rc_count=3 steady, STABLE_CYCLES=2 -> stable_count=3 and count_valid=1 exactly 4 clocks after reset release; no wrap_pulse.
- Sequence rc_count 0..6 then 0, max_count=7, sample_en=1, each value held 8 clocks, snap_ready=1 -> one wrap_pulse, wrap_total=1, snap_valid for 1 cycle with snap_wraps=1.
- Inject 1-cycle glitch 6->2->6 on rc_count -> stable_count stays 6, no wrap_pulse.
- snap_ready=0, three wraps -> snap_wraps=1 held, snap_missed pulses twice, wrap_total=3. Then snap_ready=1 -> handshake completes, FSM back to TRACK.
- WRAP_WIDTH=2, five wraps -> wrap_total saturates at 3, wrap_ovf=1 after the fourth wrap. Then assert clr mid-HOLD -> all outputs 0 immediately.
- RC_SAMPLER_RANGE_CHECK_EN defined, max_count=5, rc_count=6 stable -> range_err=1 and stays 1 after rc_count returns to 2.
